// File: rtl/segan_pkg.sv
// Shared types and constants for the SEGAN conv/deconv register-file unloaders.
package segan_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_N  = 31;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Number of two-word beats needed to stream n words.
  function automatic int unsigned beats(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/reg_file_output.sv
// Parallel-in, dual-lane shift-out unloader: captures N_REG signed words, streams two per beat.
// Optional stall counter port stall_cnt enabled by defining REG_FILE_OUTPUT_PERF_EN.
module reg_file_output
  import segan_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned N_REG = REG_N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  output logic                    load_ready,
  input  logic [WIDTH*N_REG-1:0]  all_inputs,
  output logic signed [WIDTH-1:0] out_1,
  output logic signed [WIDTH-1:0] out_2,
  output logic                    out_valid,
  output logic                    out_2_valid,
  input  logic                    out_ready,
  output logic                    out_last
`ifdef REG_FILE_OUTPUT_PERF_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(N_REG + 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        rem_q;
  logic signed [WIDTH-1:0] words_q  [N_REG];
  logic signed [WIDTH-1:0] in_words [N_REG];
  logic signed [WIDTH-1:0] shifted  [N_REG];
  logic                    transfer;
  logic                    final_beat;
  logic                    load_acc;
  logic                    has_two;

  // Unpack the flattened bank and precompute the two-word shifted view.
  for (genvar g = 0; g < N_REG; g++) begin : g_unpack
    assign in_words[g] = all_inputs[g*WIDTH +: WIDTH];
    if (g + 2 < N_REG) begin : g_shift
      assign shifted[g] = words_q[g+2];
    end else begin : g_zero
      assign shifted[g] = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    has_two     = (rem_q >= CNT_W'(2));
    out_valid   = (state_q == ST_SHIFT);
    transfer    = out_valid & out_ready;
    final_beat  = out_valid & (rem_q <= CNT_W'(2));
    load_ready  = (state_q == ST_IDLE) | (final_beat & transfer);
    load_acc    = load & load_ready;
    out_1       = words_q[0];
    out_2       = has_two ? words_q[1] : '0;
    out_2_valid = out_valid & has_two;
    out_last    = final_beat;
    if (load_acc) begin
      state_d = ST_SHIFT;
    end else if (final_beat && transfer) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Word bank and remaining count; a load on the final beat wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      for (int unsigned i = 0; i < N_REG; i++) words_q[i] <= '0;
    end else if (load_acc) begin
      rem_q <= CNT_W'(N_REG);
      for (int unsigned i = 0; i < N_REG; i++) words_q[i] <= in_words[i];
    end else if (transfer) begin
      if (final_beat) begin
        rem_q <= '0;
        for (int unsigned i = 0; i < N_REG; i++) words_q[i] <= '0;
      end else begin
        rem_q <= rem_q - CNT_W'(2);
        for (int unsigned i = 0; i < N_REG; i++) words_q[i] <= shifted[i];
      end
    end
  end

`ifdef REG_FILE_OUTPUT_PERF_EN
  // Saturating count of back-pressured cycles for the current bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (load_acc) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
